// File: rtl/gt_sar_search_4b.sv
// gt_sar_search_4b
// Successive-approximation controller that recovers an unknown 4-bit target
// by querying an external greater-than comparator. The block drives the
// comparator's in1 operand with a trial value and reads back gt, which is
// high when target > trial. The target is resolved MSB-first, one bit per
// cycle, over four search cycles.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a search (accepted in IDLE or DONE only)
//   gt     in   comparator answer for the current guess (target > guess)
//   guess  out  [3:0] trial value for the comparator's in1
//   busy   out  high during the four search cycles
//   done   out  high for the single cycle in which result becomes valid
//   result out  [3:0] recovered target, held until the next search completes
module gt_sar_search_4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gt,
  output logic [3:0] guess,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [1:0] idx, idx_nx;
  logic [3:0] acc, acc_nx;
  logic [3:0] result_nx;
  logic [3:0] cand;

  // Candidate value: bits already resolved plus the bit under test.
  function automatic logic [3:0] candidate(input logic [3:0] a, input logic [1:0] i);
    candidate = a | (4'b0001 << i);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 2'd0;
      acc    <= 4'd0;
      result <= 4'd0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      acc    <= acc_nx;
      result <= result_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    acc_nx    = acc;
    result_nx = result;
    guess     = 4'd0;
    cand      = candidate(acc, idx);

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SEARCH;
          acc_nx   = 4'd0;
          idx_nx   = 2'd3;
        end
      end

      SEARCH: begin
        // Asking "target > cand-1" is the same as "target >= cand". cand is
        // never zero, so the subtraction cannot wrap.
        guess = cand - 4'd1;
        if (gt) begin
          acc_nx = cand;
        end
        if (idx != 2'd0) begin
          idx_nx = idx - 2'd1;
        end else begin
          state_nx  = DONE;
          // Include the bit resolved in this final cycle.
          result_nx = gt ? cand : acc;
        end
      end

      DONE: begin
        if (start) begin
          state_nx = SEARCH;
          acc_nx   = 4'd0;
          idx_nx   = 2'd3;
        end else begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Pure state decodes, so both are glitch-free and mutually exclusive.
  assign busy = (state == SEARCH);
  assign done = (state == DONE);

endmodule
